// File: rtl/ifu_fetch.sv
// ifu_fetch: RV64 fetch stage with a fetch PC, a 2-entry in-order instruction queue and wrong-path response dropping.
// Define IFU_PERF_EN to add the perf_fetch_cnt / perf_drop_cnt counters.
module ifu_fetch #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(64'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             if_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] if_pc_o,
  output logic [31:0]      if_inst_o
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]      perf_fetch_cnt,
  output logic [31:0]      perf_drop_cnt
`endif
);

  logic [WIDTH-1:0] r_fpc;
  logic [WIDTH-1:0] r_pc [2];
  logic [31:0]      r_inst [2];
  logic [1:0]       r_filled;
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic [1:0]       r_drop_cnt;

  logic [1:0] w_alloc;
  logic [1:0] w_unfilled;
  logic [1:0] w_unfilled_cnt;
  logic [2:0] w_credit_used;
  logic [2:0] w_drop_sum;
  logic [1:0] w_drop_redirect;
  logic       w_req_fire;
  logic       w_pop;
  logic       w_fill_en;
  logic       w_fill_idx;
  logic       w_unused;

  // Allocated entries always form a contiguous run starting at head.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    assign w_alloc[gi] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'(gi)));
  end

  assign w_unfilled     = w_alloc & ~r_filled;
  assign w_unfilled_cnt = {1'b0, w_unfilled[0]} + {1'b0, w_unfilled[1]};
  assign w_credit_used  = {1'b0, r_count} + {1'b0, r_drop_cnt};

  assign imem_req_valid = !rst && (w_credit_used < 3'd2) && !br_taken;
  assign imem_req_addr  = r_fpc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign if_valid  = r_filled[r_head];
  assign if_pc_o   = r_pc[r_head];
  assign if_inst_o = r_inst[r_head];
  assign w_pop     = if_valid && id_ready;

  // Responses arrive in order, so the oldest unfilled entry is head unless head is already filled.
  assign w_fill_idx = w_unfilled[r_head] ? r_head : ~r_head;
  assign w_fill_en  = imem_rsp_valid && (r_drop_cnt == 2'd0) && (w_unfilled != 2'b00);

  // Every unfilled entry becomes a drop credit; a response in this same cycle settles one of them.
  assign w_drop_sum      = {1'b0, r_drop_cnt} + {1'b0, w_unfilled_cnt};
  assign w_drop_redirect = w_drop_sum[1:0] - {1'b0, imem_rsp_valid && (w_drop_sum != 3'd0)};

  assign w_unused = ^br_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc      <= RESET_PC;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= 2'd0;
      r_drop_cnt <= 2'd0;
      r_filled   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
    end else if (br_taken) begin
      r_fpc      <= {br_target[WIDTH-1:2], 2'b00};
      r_head     <= r_tail;
      r_count    <= 2'd0;
      r_filled   <= 2'b00;
      r_drop_cnt <= w_drop_redirect;
    end else begin
      if (w_req_fire) begin
        r_pc[r_tail]     <= r_fpc;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= ~r_tail;
        r_fpc            <= r_fpc + WIDTH'(4);
      end
      if (w_fill_en) begin
        r_inst[w_fill_idx]   <= imem_rsp_data;
        r_filled[w_fill_idx] <= 1'b1;
      end
      if (imem_rsp_valid && (r_drop_cnt != 2'd0)) begin
        r_drop_cnt <= r_drop_cnt - 2'd1;
      end
      if (w_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_req_fire} - {1'b0, w_pop};
    end
  end

`ifdef IFU_PERF_EN
  logic [63:0] r_perf_fetch;
  logic [31:0] r_perf_drop;
  logic        w_discard;

  assign w_discard = imem_rsp_valid && (br_taken || (r_drop_cnt != 2'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetch <= r_perf_fetch + 64'd1;
      end
      if (w_discard) begin
        r_perf_drop <= r_perf_drop + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed fetch/stall/redirect/reset cases plus a randomized memory
// and decode stream checked against a PC+4 reference model.
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic        if_valid;
  logic        id_ready = 1'b0;
  logic [63:0] if_pc_o;
  logic [31:0] if_inst_o;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(.WIDTH(64), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: in-order queue of outstanding requests with their due cycle and wrong-path mark.
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  bit          mq_wrong[$];
  logic [63:0] dec_log[$];
  logic [63:0] exp_fetch;
  logic [63:0] exp_dec;
  logic [63:0] last_req_addr;
  bit          last_req_fire;
  int          cyc = 0;
  int          req_acc;
  int          exp_drops;
  longint      exp_fetch_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] addr);
    return addr[33:2] ^ addr[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic model_clear();
    mq_addr.delete();
    mq_due.delete();
    mq_wrong.delete();
    dec_log.delete();
    exp_fetch     = RST_PC;
    exp_dec       = RST_PC;
    req_acc       = 0;
    exp_drops     = 0;
    exp_fetch_cnt = 0;
    last_req_fire = 1'b0;
    last_req_addr = '0;
  endtask

  task automatic check_perf(input string tag);
`ifdef IFU_PERF_EN
    check({tag, "_perf_fetch"}, perf_fetch_cnt, 64'(exp_fetch_cnt));
    check({tag, "_perf_drop"}, 64'(perf_drop_cnt), 64'(exp_drops));
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    br_taken       = 1'b0;
    imem_rsp_valid = 1'b0;
    rst            = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs at negedge, sample 1ns later, update the reference model.
  task automatic tick(input bit rdy, input bit idr, input bit br, input logic [63:0] tgt,
                      input bit rsp_en, input int dly_max);
    logic [63:0] a;
    bit          rsp_now;
    bit          rsp_wrong;
    @(negedge clk);
    imem_req_ready = rdy;
    id_ready       = idr;
    br_taken       = br;
    br_target      = tgt;
    rsp_now        = 1'b0;
    rsp_wrong      = 1'b0;
    if (rsp_en && (mq_addr.size() > 0) && (mq_due[0] <= cyc)) begin
      rsp_now        = 1'b1;
      a              = mq_addr.pop_front();
      void'(mq_due.pop_front());
      rsp_wrong      = mq_wrong.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(a);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    last_req_fire = 1'b0;
    if (br) begin
      check("req_blocked_by_br", 64'(imem_req_valid), 64'(0));
      foreach (mq_wrong[i]) mq_wrong[i] = 1'b1;
      if (rsp_now) exp_drops++;
    end else if (rsp_now && rsp_wrong) begin
      exp_drops++;
    end
    if (imem_req_valid && rdy) begin
      check("req_addr", imem_req_addr, exp_fetch);
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + 1 + int'($urandom_range(0, dly_max)));
      mq_wrong.push_back(1'b0);
      req_acc++;
      last_req_fire = 1'b1;
      last_req_addr = imem_req_addr;
      check("inflight_le2", 64'(mq_addr.size() <= 2), 64'(1));
      exp_fetch = exp_fetch + 64'd4;
    end
    if (if_valid && idr) begin
      exp_fetch_cnt++;
      if (!br) begin
        $display("[TB] dec pc=%h inst=%h", if_pc_o, if_inst_o);
        check("dec_pc", if_pc_o, exp_dec);
        check("dec_inst", 64'(if_inst_o), 64'(inst_of(exp_dec)));
        dec_log.push_back(if_pc_o);
        exp_dec = exp_dec + 64'd4;
      end
    end
    if (br) begin
      exp_fetch = {tgt[63:2], 2'b00};
      exp_dec   = exp_fetch;
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rb;
    logic [63:0] rt;
    model_clear();

    // Reset values
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'(0));
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_if_valid", 64'(if_valid), 64'(0));
    check("rst_if_pc", if_pc_o, 64'(0));
    check("rst_if_inst", 64'(if_inst_o), 64'(0));
    check_perf("rst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();

    // Zero-wait memory, decode always ready
    tick(1, 1, 0, '0, 1, 0);
    check("first_req_fire", 64'(last_req_fire), 64'(1));
    check("first_req_addr", last_req_addr, RST_PC);
    repeat (7) tick(1, 1, 0, '0, 1, 0);
    check("a_dec_n", 64'(dec_log.size() >= 3), 64'(1));
    if (dec_log.size() >= 3) begin
      check("a_dec0", dec_log[0], RST_PC);
      check("a_dec1", dec_log[1], RST_PC + 64'd4);
      check("a_dec2", dec_log[2], RST_PC + 64'd8);
    end

    // Decode stalled for 10 cycles
    do_reset();
    repeat (10) tick(1, 0, 0, '0, 1, 0);
    check("stall_req_count", 64'(req_acc), 64'(2));
    check("stall_req_valid", 64'(imem_req_valid), 64'(0));
    check("stall_head_pc", if_pc_o, RST_PC);
    repeat (8) tick(1, 1, 0, '0, 1, 0);
    check("b_dec_n", 64'(dec_log.size() >= 3), 64'(1));
    if (dec_log.size() >= 3) begin
      check("b_dec0", dec_log[0], RST_PC);
      check("b_dec1", dec_log[1], RST_PC + 64'd4);
      check("b_dec2", dec_log[2], RST_PC + 64'd8);
    end

    // Redirect with two requests outstanding and unfilled
    do_reset();
    tick(1, 1, 0, '0, 0, 0);
    tick(1, 1, 0, '0, 0, 0);
    tick(1, 1, 1, 64'h8000_0102, 0, 0);
    tick(1, 1, 0, '0, 0, 0);
    check("c_req_blocked", 64'(imem_req_valid), 64'(0));
    check("c_if_valid0", 64'(if_valid), 64'(0));
    tick(1, 1, 0, '0, 1, 0);
    check("c_if_valid1", 64'(if_valid), 64'(0));
    tick(1, 1, 0, '0, 1, 0);
    check("c_if_valid2", 64'(if_valid), 64'(0));
    check("c_new_req_fire", 64'(last_req_fire), 64'(1));
    check("c_new_req_addr", last_req_addr, 64'h8000_0100);
    repeat (6) tick(1, 1, 0, '0, 1, 0);
    check("c_dec_n", 64'(dec_log.size() >= 1), 64'(1));
    if (dec_log.size() >= 1) check("c_dec0", dec_log[0], 64'h8000_0100);
    check_perf("c");

    // Redirect in the same cycle as a response, one entry unfilled
    do_reset();
    tick(1, 0, 0, '0, 0, 0);
    tick(1, 0, 1, 64'h8000_0200, 1, 0);
    tick(1, 0, 0, '0, 0, 0);
    check("d_req1_fire", 64'(last_req_fire), 64'(1));
    tick(1, 0, 0, '0, 0, 0);
    check("d_req2_fire", 64'(last_req_fire), 64'(1));
    repeat (6) tick(0, 1, 0, '0, 1, 0);
    check("d_dec_n", 64'(dec_log.size() >= 2), 64'(1));
    if (dec_log.size() >= 1) check("d_dec0", dec_log[0], 64'h8000_0200);
    check_perf("d");

    // Randomized memory stalls, response delays, decode backpressure and redirects
    do_reset();
    for (int k = 0; k < 20000 && dec_log.size() < 1000; k++) begin
      rb = ($urandom_range(0, 99) < 2);
      rt = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) rt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      tick($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, rb, rt, 1, 5);
    end
    check("rand_dec_count", 64'(dec_log.size() >= 1000), 64'(1));
    check_perf("rand");

    // Reset asserted mid-stream with both entries filled
    do_reset();
    repeat (6) tick(1, 0, 0, '0, 1, 0);
    check("f_pre_if_valid", 64'(if_valid), 64'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("f_if_valid_drop", 64'(if_valid), 64'(0));
    check("f_req_valid_drop", 64'(imem_req_valid), 64'(0));
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    br_taken       = 1'b0;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    check("f_req_addr_after", imem_req_addr, RST_PC);
    check_perf("f");
    tick(1, 1, 0, '0, 1, 0);
    check("f_restart_fire", 64'(last_req_fire), 64'(1));
    repeat (6) tick(1, 1, 0, '0, 1, 0);
    check("f_dec_n", 64'(dec_log.size() >= 1), 64'(1));
    if (dec_log.size() >= 1) check("f_dec0", dec_log[0], RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
